parking_count_ctrl: RTL
=======================

Name: parking_count_ctrl

Overview:
- Occupancy controller for the smart parking system.
- Arbitrates entry and exit requests from the gate sensors.
- Sequences a single shared external 4-bit adder/subtractor to update the occupied-space count, then reuses the same adder to compute free spaces.
- Publishes count, free, full/empty flags and per-request ack/nack pulses.

Parameters:
- CAPACITY, 10, number of parking spaces; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- entry_req  in  1  level request, car at entry gate; held until entry_ack or entry_nack is seen.
- exit_req  in  1  level request, car at exit gate; same handshake.
- entry_ack  out  1  one-cycle pulse, entry accepted and count updated.
- entry_nack  out  1  one-cycle pulse, entry refused (lot full or error).
- exit_ack  out  1  one-cycle pulse, exit accepted.
- exit_nack  out  1  one-cycle pulse, exit refused (lot empty or error).
- as_a  out  4  adder operand A.
- as_b  out  4  adder operand B.
- as_sel  out  1  adder mode; 0 = A+B, 1 = A-B.
- as_s  in  4  adder result (combinational from as_a/as_b/as_sel).
- as_cout  in  1  adder carry out (1 = no borrow in subtract mode).
- count  out  4  occupied spaces.
- free  out  4  CAPACITY - count.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- err  out  1  sticky adder consistency error.

Behaviour:
- Reset (rst_n low at a clk edge):
  - count = 0, free = CAPACITY, full = 0, empty = 1, err = 0.
  - All ack/nack = 0, state = IDLE, priority pointer = ENTRY.
  - Reset mid-transaction abandons it; no ack or nack is issued.
- FSM states: IDLE, UPDATE, FREE, REJECT.
- IDLE:
  - as_a = 0, as_b = 0, as_sel = 0.
  - Requests are sampled here only.
  - Only one request high: that one wins.
  - Both high: the winner is the priority pointer; the pointer toggles to the other side after each grant (ack or nack).
  - No request: stay in IDLE.
  - Winner is entry with full = 1, winner is exit with empty = 1, or err = 1: go to REJECT.
  - Otherwise go to UPDATE.
- UPDATE:
  - as_a = count, as_b = 1, as_sel = 0 for entry, 1 for exit.
  - At the edge, count <= as_s, then go to FREE.
  - Consistency check: entry with as_cout = 1, or exit with as_cout = 0, sets err, leaves count unchanged and goes to REJECT.
- FREE:
  - as_a = CAPACITY, as_b = count (already updated), as_sel = 1.
  - At the edge, free <= as_s and full/empty are recomputed from count.
  - The winner's ack is high for this one cycle; then go to IDLE.
- REJECT: the winner's nack is high for exactly one cycle; then go to IDLE.
- Transaction latency:
  - Accepted: request seen in IDLE cycle N, ack in cycle N+2, next arbitration in N+3.
  - Rejected: nack in cycle N+1.
- Requester handshake: the requester must drop req on the edge at which it sees ack/nack high. A req still high in the next IDLE is treated as a new request.
- The losing request stays pending and is served in the next arbitration; it is never dropped.
- Outputs count/free/full/empty are registered and stable outside the UPDATE→FREE window. free lags count by one cycle.
- err clears only on reset; while set, every request is nacked.

Optional Feature:
- Macro PARK_STATS_EN.
- When defined:
  - Adds output reject_cnt [7:0], reset to 0.
  - Increments on every nack pulse, saturating at 255.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single entry from reset (CAPACITY=10): entry_req → entry_ack 2 cycles later; count=1, free=9, empty=0; as_a=0, as_b=1, as_sel=0 in UPDATE.
- Fill to capacity: 10 entries → count=10, full=1, free=0; 11th entry_req → entry_nack one cycle after sampling, count unchanged.
- Exit on empty: exit_req immediately after reset → exit_nack, count=0, empty=1, no adder activity (as_a=as_b=0).
- Simultaneous entry_req and exit_req held with count=5: entry acked first (count=6), then exit acked (count=5); the pointer then favours exit on the next collision.
- Adder fault injection: force as_cout=1 during an entry UPDATE → err=1, count unchanged, entry_nack; a subsequent exit_req is also nacked. With PARK_STATS_EN, reject_cnt=2.
- Reset mid-UPDATE with rst_n=0 → next cycle count=0, free=CAPACITY, no ack; after release, a pending request is served normally.

Source files
------------

// File: rtl/parking_count_ctrl.sv
// Occupancy controller for the smart parking system.
// Arbitrates entry/exit gate requests, sequences one shared external 4-bit
// adder/subtractor to update the occupied count and then the free count,
// and publishes count/free/full/empty/err plus one-cycle ack/nack pulses.
// Optional feature macro: PARK_STATS_EN adds a saturating reject counter
// output (reject_cnt) that increments on every nack pulse.
module parking_count_ctrl #(
  parameter int CAPACITY = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       exit_req,
  output logic       entry_ack,
  output logic       entry_nack,
  output logic       exit_ack,
  output logic       exit_nack,
  output logic [3:0] as_a,
  output logic [3:0] as_b,
  output logic       as_sel,
  input  logic [3:0] as_s,
  input  logic       as_cout,
  output logic [3:0] count,
  output logic [3:0] free,
  output logic       full,
  output logic       empty,
  output logic       err
`ifdef PARK_STATS_EN
  ,
  output logic [7:0] reject_cnt
`endif
);

  localparam logic [3:0] CAP4 = 4'(CAPACITY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_FREE,
    ST_REJECT
  } state_t;

  state_t     state_q, state_d;
  logic       win_exit_q, win_exit_d;   // side being served: 0 = entry, 1 = exit
  logic       ptr_exit_q, ptr_exit_d;   // collision priority: 0 = entry, 1 = exit
  logic [3:0] count_q, count_d;
  logic [3:0] free_q, free_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;
  logic       err_q, err_d;
  logic       entry_ack_q, entry_ack_d;
  logic       entry_nack_q, entry_nack_d;
  logic       exit_ack_q, exit_ack_d;
  logic       exit_nack_q, exit_nack_d;
`ifdef PARK_STATS_EN
  logic [7:0] reject_cnt_q, reject_cnt_d;
`endif

  logic grant_exit;
  logic refuse;
  logic adder_bad;

  // Drive the shared adder operands from the current state only.
  always_comb begin
    as_a   = '0;
    as_b   = '0;
    as_sel = 1'b0;
    case (state_q)
      ST_UPDATE: begin
        as_a   = count_q;
        as_b   = 4'd1;
        as_sel = win_exit_q;
      end
      ST_FREE: begin
        as_a   = CAP4;
        as_b   = count_q;
        as_sel = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state logic: arbitration, count update, free update and pulse set-up.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    win_exit_d   = win_exit_q;
    ptr_exit_d   = ptr_exit_q;
    count_d      = count_q;
    free_d       = free_q;
    full_d       = full_q;
    empty_d      = empty_q;
    err_d        = err_q;
    entry_ack_d  = 1'b0;
    entry_nack_d = 1'b0;
    exit_ack_d   = 1'b0;
    exit_nack_d  = 1'b0;
    grant_exit   = exit_req && (!entry_req || ptr_exit_q);
    refuse       = err_q || (grant_exit ? empty_q : full_q);
    adder_bad    = win_exit_q ? !as_cout : as_cout;

    case (state_q)
      ST_IDLE: begin
        if (entry_req || exit_req) begin
          win_exit_d = grant_exit;
          // Only a contested grant moves the priority pointer.
          if (entry_req && exit_req) ptr_exit_d = !grant_exit;
          if (refuse) begin
            state_d      = ST_REJECT;
            entry_nack_d = !grant_exit;
            exit_nack_d  = grant_exit;
          end else begin
            state_d = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: begin
        // A carry on +1 or a borrow on -1 means the adder disagrees with
        // the range we already guaranteed in IDLE.
        if (adder_bad) begin
          err_d        = 1'b1;
          state_d      = ST_REJECT;
          entry_nack_d = !win_exit_q;
          exit_nack_d  = win_exit_q;
        end else begin
          count_d     = as_s;
          state_d     = ST_FREE;
          entry_ack_d = !win_exit_q;
          exit_ack_d  = win_exit_q;
        end
      end
      ST_FREE: begin
        free_d  = as_s;
        full_d  = (count_q == CAP4);
        empty_d = (count_q == 4'd0);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef PARK_STATS_EN
  // Saturating count of refused requests.
  always_comb begin
    reject_cnt_d = reject_cnt_q;
    if ((entry_nack_d || exit_nack_d) && (reject_cnt_q != 8'hFF))
      reject_cnt_d = reject_cnt_q + 8'd1;
  end
`endif

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs; reset is checked inside the clocked block.
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      win_exit_q   <= 1'b0;
      ptr_exit_q   <= 1'b0;
      count_q      <= 4'd0;
      free_q       <= CAP4;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      err_q        <= 1'b0;
      entry_ack_q  <= 1'b0;
      entry_nack_q <= 1'b0;
      exit_ack_q   <= 1'b0;
      exit_nack_q  <= 1'b0;
`ifdef PARK_STATS_EN
      reject_cnt_q <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      win_exit_q   <= win_exit_d;
      ptr_exit_q   <= ptr_exit_d;
      count_q      <= count_d;
      free_q       <= free_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      err_q        <= err_d;
      entry_ack_q  <= entry_ack_d;
      entry_nack_q <= entry_nack_d;
      exit_ack_q   <= exit_ack_d;
      exit_nack_q  <= exit_nack_d;
`ifdef PARK_STATS_EN
      reject_cnt_q <= reject_cnt_d;
`endif
    end
  end

  assign entry_ack  = entry_ack_q;
  assign entry_nack = entry_nack_q;
  assign exit_ack   = exit_ack_q;
  assign exit_nack  = exit_nack_q;
  assign count      = count_q;
  assign free       = free_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign err        = err_q;
`ifdef PARK_STATS_EN
  assign reject_cnt = reject_cnt_q;
`endif

endmodule
